runahead_spec_clear_queue: RTL and testbench
============================================

# runahead_spec_clear_queue

Tracks speculative instructions in the runahead instruction FIFO, grouped into speculation windows. It resolves each closed window in order: a mispredicted window is flushed from the runahead FIFO tail, and a correctly predicted window is retired by counting its issued instructions. It sits beside the runahead FIFO, between fetch/branch resolution and runahead issue. It supersedes the single-counter clear queue with working storage, flush handshaking, validation counting, overflow detection and optional statistics.

## Interface
- COUNTERBITWIDTH, 6: width of every instruction count (window size, remaining count, flush count).
- QUEUEDEPTH, 8: number of closed windows held; must be ≥1, power of two not required.
- clk  in  1  clock.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; when low all state holds and all inputs are ignored.
- SpecEnqueue  in  1  one speculative instruction written into the runahead FIFO this cycle.
- SpecIssue  in  1  one speculative instruction issued from the runahead FIFO head this cycle.
- EndSpeculationPulse  in  1  closes the open window.
- MispredictedPulse  in  1  qualifies EndSpeculationPulse; ignored without it.
- ClearQueueFull  out  1  occupancy == QUEUEDEPTH; fetch must stall speculation starts.
- ClearQueueValid  out  1  head entry present.
- CurrentSpeculativeDepth  out  COUNTERBITWIDTH  open-window count.
- HoldIssue  out  1  head is mispredicted; issuer must not assert SpecIssue.
- FlushValid  out  1  flush request to the runahead FIFO tail.
- FlushCount  out  COUNTERBITWIDTH  entries to remove from the tail.
- FlushAck  in  1  runahead FIFO accepted the flush.
- ValidatedPulse  out  1  one correctly predicted window fully retired.
- ErrorSticky  out  2  {counter overflow, queue overflow}; cleared only by reset.

## Operation
- Open counter:
  - Queue empty: counter += SpecEnqueue − SpecIssue.
  - Queue non-empty: counter += SpecEnqueue; issues belong to the head.
  - Counter never wraps. An increment at all-ones holds the value and sets ErrorSticky[1].
- End of window: on EndSpeculationPulse, next = counter plus the same-cycle adjustment.
  - next ≠ 0: push {MispredictedPulse, next} and clear the counter.
  - next == 0: nothing is pushed, and the counter stays 0.
  - Push while full: entry dropped, counter cleared, ErrorSticky[0] set.
- Head remaining register: loaded with the entry count when the entry becomes head.
- Correct head:
  - Each SpecIssue decrements remaining.
  - remaining==1 with SpecIssue pops the head, and ValidatedPulse fires next cycle.
- Mispredicted head:
  - FlushValid=1, FlushCount=remaining, HoldIssue=1.
  - On FlushAck the head pops. No ValidatedPulse.
  - SpecIssue while HoldIssue is a protocol violation. It is ignored and does not decrement.
- Head-loader states: EMPTY → LOAD (entry arrives, remaining loaded) → ACTIVE_OK or ACTIVE_FLUSH → back to LOAD on pop if occupancy > 1, else EMPTY.
- Simultaneous push and pop at full: allowed, not an overflow.

## Timing
- Reset values:
  - Counter, occupancy, remaining and ErrorSticky: 0.
  - ClearQueueValid, FlushValid, HoldIssue, ValidatedPulse, ClearQueueFull: 0.
  - FlushCount: 0.
- All outputs are registered except HoldIssue, which is combinational from registered head state.
- Push to ClearQueueValid: 1 cycle when the queue is empty.
- Push to FlushValid: 1 cycle for a mispredicted entry pushed into an empty queue.
- FlushAck to FlushValid drop: 1 cycle. A next mispredicted entry reasserts FlushValid the following cycle.
- Last issue to ValidatedPulse: 1 cycle; the pulse is 1 cycle wide.
- ClearQueueFull updates the cycle after the occupancy change.
- Reset asserted mid-flush: state clears immediately. The runahead FIFO must be reset by the same signal.

## Configuration
- RUNAHEAD_CLEARQ_STATS_EN defined: adds outputs FlushedWindows[15:0] and ValidatedWindows[15:0].
  - Saturating counts of flush pops and validation pops.
  - Reset to 0.
- Not defined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Package runahead_pkg:
  - typedef clearq_entry_t {logic mispredicted; logic [COUNTERBITWIDTH-1:0] count}.
  - Head-loader state enum.
  - ErrorSticky bit index constants.
- One sub-module, runahead_clearq_fifo.
  - Parametrised circular buffer of clearq_entry_t with async active-low reset.
  - Push/pop, occupancy and full/empty are registered.
  - Pointer wrap at QUEUEDEPTH−1 → 0.
- Counter, head register and flush/validate logic live in the top.

## Test plan
- 5 SpecEnqueue, End correct, then 5 SpecIssue → push {0,5}; ValidatedPulse once, 1 cycle after the 5th issue; queue empty.
- 3 SpecEnqueue, End + Mispredicted → FlushValid with FlushCount=3, HoldIssue=1; FlushAck → FlushValid drops next cycle; no ValidatedPulse.
- Queue empty: 4 SpecEnqueue, 4 SpecIssue, End → nothing pushed; ClearQueueValid stays 0; depth 0.
- Push 8 windows with QUEUEDEPTH=8 → ClearQueueFull=1; 9th End → ErrorSticky=2'b01, occupancy stays 8; pop+push same cycle keeps full without error.
- Windows {0,2},{1,3},{0,1}: 2 issues → ValidatedPulse; flush 3 on FlushAck; 1 issue → ValidatedPulse; pointers wrap correctly.
- Reset asserted during FlushValid → all outputs 0 asynchronously; the next End with count 2 is handled as the first window.

Source files
------------

// File: rtl/runahead_spec_clear_queue_pkg.sv
// Shared types for the runahead speculative clear queue.
//   clearq_entry_t : one closed speculation window {mispredicted, instruction count}
//   head_state_e   : head-loader states
//   ERR_*          : ErrorSticky bit positions
// The entry count width is fixed here; the top's COUNTERBITWIDTH must match CLEARQ_CNT_W.
package runahead_pkg;

  localparam int unsigned CLEARQ_CNT_W = 6;

  typedef struct packed {
    logic                    mispredicted;
    logic [CLEARQ_CNT_W-1:0] count;
  } clearq_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StLoad,
    StActiveOk,
    StActiveFlush
  } head_state_e;

  localparam int unsigned ERR_Q_OVF   = 0;  // window pushed while queue full
  localparam int unsigned ERR_CNT_OVF = 1;  // open counter incremented at all-ones

endpackage

// File: rtl/runahead_spec_clear_queue_if.sv
// Handshake bundle between the clear queue and fetch / branch resolution / runahead issue.
//   slave  : the clear queue (consumes speculation events, drives flush/validate)
//   master : the surrounding pipeline
// Optional macro RUNAHEAD_CLEARQ_STATS_EN adds FlushedWindows / ValidatedWindows.
interface runahead_spec_clear_queue_if #(
  parameter int unsigned COUNTERBITWIDTH = 6
);
  logic                       clk_en;
  logic                       SpecEnqueue;
  logic                       SpecIssue;
  logic                       EndSpeculationPulse;
  logic                       MispredictedPulse;
  logic                       FlushAck;
  logic                       ClearQueueFull;
  logic                       ClearQueueValid;
  logic [COUNTERBITWIDTH-1:0] CurrentSpeculativeDepth;
  logic                       HoldIssue;
  logic                       FlushValid;
  logic [COUNTERBITWIDTH-1:0] FlushCount;
  logic                       ValidatedPulse;
  logic [1:0]                 ErrorSticky;
`ifdef RUNAHEAD_CLEARQ_STATS_EN
  logic [15:0]                FlushedWindows;
  logic [15:0]                ValidatedWindows;

  modport slave (
    input  clk_en, SpecEnqueue, SpecIssue, EndSpeculationPulse, MispredictedPulse, FlushAck,
    output ClearQueueFull, ClearQueueValid, CurrentSpeculativeDepth, HoldIssue, FlushValid,
           FlushCount, ValidatedPulse, ErrorSticky, FlushedWindows, ValidatedWindows
  );
  modport master (
    output clk_en, SpecEnqueue, SpecIssue, EndSpeculationPulse, MispredictedPulse, FlushAck,
    input  ClearQueueFull, ClearQueueValid, CurrentSpeculativeDepth, HoldIssue, FlushValid,
           FlushCount, ValidatedPulse, ErrorSticky, FlushedWindows, ValidatedWindows
  );
`else
  modport slave (
    input  clk_en, SpecEnqueue, SpecIssue, EndSpeculationPulse, MispredictedPulse, FlushAck,
    output ClearQueueFull, ClearQueueValid, CurrentSpeculativeDepth, HoldIssue, FlushValid,
           FlushCount, ValidatedPulse, ErrorSticky
  );
  modport master (
    output clk_en, SpecEnqueue, SpecIssue, EndSpeculationPulse, MispredictedPulse, FlushAck,
    input  ClearQueueFull, ClearQueueValid, CurrentSpeculativeDepth, HoldIssue, FlushValid,
           FlushCount, ValidatedPulse, ErrorSticky
  );
`endif
endinterface

// File: rtl/runahead_clearq_fifo.sv
// Circular buffer of closed speculation windows.
//   push_i/data_i : write one entry at the tail (caller never pushes when full without popping)
//   pop_i         : drop the head entry (caller never pops when empty)
//   head_o        : current head entry, read from registered storage
//   empty_o/full_o/occ_o : registered occupancy status
module runahead_clearq_fifo
  import runahead_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned OccW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  clearq_entry_t   data_i,
  input  logic            pop_i,
  output clearq_entry_t   head_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [OccW-1:0] occ_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(Depth - 1);

  clearq_entry_t   mem_q [Depth];
  ptr_t            wr_q, wr_d, rd_q, rd_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            empty_q, full_q;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d  = push_i ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop_i ? ptr_inc(rd_q) : rd_q;
    occ_d = occ_q;
    if (push_i && !pop_i) begin
      occ_d = occ_q + 1'b1;
    end else if (!push_i && pop_i) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      empty_q <= (occ_d == '0);
      full_q  <= (occ_d == OccW'(Depth));
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/runahead_spec_clear_queue.sv
// Runahead speculative clear queue: counts instructions of the open speculation window,
// queues closed windows, then resolves the head window in order (flush from the runahead
// FIFO tail if mispredicted, retire by counting issues if correct).
//   clk, async_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : speculation events in; full/valid/depth/hold/flush/validate/error out
// Optional macro RUNAHEAD_CLEARQ_STATS_EN adds saturating FlushedWindows/ValidatedWindows.
module runahead_spec_clear_queue
  import runahead_pkg::*;
#(
  parameter int unsigned COUNTERBITWIDTH = CLEARQ_CNT_W,
  parameter int unsigned QUEUEDEPTH      = 8
) (
  input logic                        clk,
  input logic                        async_rst_n,
  runahead_spec_clear_queue_if.slave bus
);

  localparam int unsigned OccW = $clog2(QUEUEDEPTH + 1);
  typedef logic [COUNTERBITWIDTH-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  // Inputs are gated so nothing reaches the FIFO while clk_en is low.
  logic enq, iss, end_p, mis, ack;
  assign enq   = bus.clk_en & bus.SpecEnqueue;
  assign iss   = bus.clk_en & bus.SpecIssue;
  assign end_p = bus.clk_en & bus.EndSpeculationPulse;
  assign mis   = bus.MispredictedPulse;
  assign ack   = bus.clk_en & bus.FlushAck;

  head_state_e   st_q, st_d;
  cnt_t          cnt_q, cnt_d, cnt_adj;
  cnt_t          rem_q, rem_d;
  logic          flush_valid_q, flush_valid_d;
  cnt_t          flush_count_q, flush_count_d;
  logic          validated_q;
  logic [1:0]    err_q, err_d;
  logic          cnt_ovf, q_ovf;
  logic          push, pop, pop_ok, pop_flush;
  clearq_entry_t push_entry, fifo_head;
  logic          fifo_empty, fifo_full;
  logic [OccW-1:0] fifo_occ;

  runahead_clearq_fifo #(
    .Depth (QUEUEDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (async_rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .occ_o   (fifo_occ)
  );

  // Head pop decision; depends only on head state and inputs, never on push.
  always_comb begin
    pop_ok    = 1'b0;
    pop_flush = 1'b0;
    unique case (st_q)
      StLoad:        pop_ok = iss && !fifo_head.mispredicted && (fifo_head.count == cnt_t'(1));
      StActiveOk:    pop_ok = iss && (rem_q == cnt_t'(1));
      StActiveFlush: pop_flush = ack;
      default:       ;
    endcase
    pop = pop_ok | pop_flush;
  end

  // Open-window counter and window close. Issues belong to the head once the queue is occupied.
  always_comb begin
    cnt_adj = cnt_q;
    cnt_ovf = 1'b0;
    if (enq && !(fifo_empty && iss)) begin
      if (cnt_q == CntMax) cnt_ovf = 1'b1;
      else                 cnt_adj = cnt_q + 1'b1;
    end else if (!enq && fifo_empty && iss) begin
      // Issuing past an empty window is a protocol slip; saturate rather than wrap.
      if (cnt_q != '0) cnt_adj = cnt_q - 1'b1;
    end

    cnt_d                   = cnt_adj;
    push                    = 1'b0;
    q_ovf                   = 1'b0;
    push_entry.mispredicted = mis;
    push_entry.count        = cnt_adj;
    if (end_p) begin
      cnt_d = '0;
      if (cnt_adj != '0) begin
        // A same-cycle pop frees a slot, so push at full with pop is legal.
        if (fifo_full && !pop) q_ovf = 1'b1;
        else                   push  = 1'b1;
      end
    end
  end

  // Head loader. A push into an empty queue is bypassed straight into the head so the
  // head acts one cycle after the push; after a pop the next head takes a LOAD cycle.
  always_comb begin
    st_d  = st_q;
    rem_d = rem_q;
    case (st_q)
      StEmpty: begin
        if (push) begin
          rem_d = push_entry.count;
          st_d  = push_entry.mispredicted ? StActiveFlush : StActiveOk;
        end
      end
      StLoad: begin
        rem_d = fifo_head.count;
        if (fifo_head.mispredicted) begin
          st_d = StActiveFlush;
        end else begin
          st_d = StActiveOk;
          if (iss) rem_d = fifo_head.count - 1'b1;
        end
      end
      StActiveOk: begin
        if (iss) rem_d = rem_q - 1'b1;
      end
      default: ;
    endcase
    if (pop) begin
      rem_d = '0;
      st_d  = ((fifo_occ > OccW'(1)) || push) ? StLoad : StEmpty;
    end

    flush_valid_d            = (st_d == StActiveFlush);
    flush_count_d            = flush_valid_d ? rem_d : '0;
    err_d                    = err_q;
    err_d[ERR_CNT_OVF]       = err_q[ERR_CNT_OVF] | cnt_ovf;
    err_d[ERR_Q_OVF]         = err_q[ERR_Q_OVF] | q_ovf;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      st_q          <= StEmpty;
      cnt_q         <= '0;
      rem_q         <= '0;
      flush_valid_q <= 1'b0;
      flush_count_q <= '0;
      validated_q   <= 1'b0;
      err_q         <= '0;
    end else if (bus.clk_en) begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      flush_valid_q <= flush_valid_d;
      flush_count_q <= flush_count_d;
      validated_q   <= pop_ok;
      err_q         <= err_d;
    end
  end

  assign bus.ClearQueueFull          = fifo_full;
  assign bus.ClearQueueValid         = !fifo_empty;
  assign bus.CurrentSpeculativeDepth = cnt_q;
  assign bus.HoldIssue               = (st_q == StActiveFlush) ||
                                       ((st_q == StLoad) && fifo_head.mispredicted);
  assign bus.FlushValid              = flush_valid_q;
  assign bus.FlushCount              = flush_count_q;
  assign bus.ValidatedPulse          = validated_q;
  assign bus.ErrorSticky             = err_q;

`ifdef RUNAHEAD_CLEARQ_STATS_EN
  logic [15:0] flushed_q, flushed_d, validated_cnt_q, validated_cnt_d;

  always_comb begin
    flushed_d       = flushed_q;
    validated_cnt_d = validated_cnt_q;
    if (pop_flush && (flushed_q != 16'hffff))    flushed_d       = flushed_q + 1'b1;
    if (pop_ok && (validated_cnt_q != 16'hffff)) validated_cnt_d = validated_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      flushed_q       <= '0;
      validated_cnt_q <= '0;
    end else if (bus.clk_en) begin
      flushed_q       <= flushed_d;
      validated_cnt_q <= validated_cnt_d;
    end
  end

  assign bus.FlushedWindows   = flushed_q;
  assign bus.ValidatedWindows = validated_cnt_q;
`endif

endmodule

// File: tb/tb_runahead_spec_clear_queue.sv
module tb_runahead_spec_clear_queue;
  localparam int unsigned CW    = 6;
  localparam int unsigned DEPTH = 8;
  localparam int          MAXC  = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  runahead_spec_clear_queue_if #(.COUNTERBITWIDTH(CW)) bus ();

  runahead_spec_clear_queue #(
    .COUNTERBITWIDTH (CW),
    .QUEUEDEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of closed windows plus the head's remaining count.
  typedef struct {
    bit mis;
    int cnt;
  } win_t;

  win_t m_q[$];
  int   m_cnt;
  int   m_rem;
  bit   m_loaded;  // head remaining established (a popped-to head needs one load cycle)
  bit   m_vp;
  bit   m_err0, m_err1;
  int   m_flushed, m_validated;

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_rem = 0; m_loaded = 0; m_vp = 0;
    m_err0 = 0; m_err1 = 0; m_flushed = 0; m_validated = 0;
  endtask

  task automatic model_step();
    bit en, enq, iss, endp, mis, ack, empty, pop_ok, pop_fl, push;
    int r, nxt;
    win_t w;
    en = bus.clk_en; enq = bus.SpecEnqueue; iss = bus.SpecIssue;
    endp = bus.EndSpeculationPulse; mis = bus.MispredictedPulse; ack = bus.FlushAck;
    if (!en) return;
    empty = (m_q.size() == 0);
    pop_ok = 0; pop_fl = 0; push = 0; r = 0;
    if (!empty) begin
      if (m_q[0].mis) begin
        if (m_loaded && ack) pop_fl = 1;
      end else begin
        r = m_loaded ? m_rem : m_q[0].cnt;
        if (iss) begin
          r--;
          if (r == 0) pop_ok = 1;
        end
      end
    end
    nxt = m_cnt;
    if (enq && !(empty && iss)) begin
      if (m_cnt == MAXC) m_err1 = 1;
      else nxt++;
    end else if (!enq && empty && iss && m_cnt > 0) begin
      nxt--;
    end
    if (endp) begin
      if (nxt != 0) begin
        if (m_q.size() < DEPTH || pop_ok || pop_fl) push = 1;
        else m_err0 = 1;
      end
      w.mis = mis; w.cnt = nxt;
      nxt = 0;
    end
    m_cnt = nxt;
    if (pop_ok || pop_fl) void'(m_q.pop_front());
    if (push) m_q.push_back(w);
    if (pop_ok || pop_fl) m_loaded = 0;
    else if (empty && push) begin
      m_loaded = 1; m_rem = w.cnt;
    end else if (!empty) begin
      m_loaded = 1; m_rem = m_q[0].mis ? m_q[0].cnt : r;
    end
    m_vp = pop_ok;
    if (pop_fl && m_flushed < 65535) m_flushed++;
    if (pop_ok && m_validated < 65535) m_validated++;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      bit hd_mis, fv;
      hd_mis = (m_q.size() != 0) && m_q[0].mis;
      fv     = hd_mis && m_loaded;
      chk("valid", bus.ClearQueueValid, m_q.size() != 0);
      chk("full", bus.ClearQueueFull, m_q.size() == DEPTH);
      chk("depth", bus.CurrentSpeculativeDepth, m_cnt);
      chk("hold", bus.HoldIssue, hd_mis);
      chk("flush_valid", bus.FlushValid, fv);
      chk("flush_count", bus.FlushCount, fv ? m_rem : 0);
      chk("validated", bus.ValidatedPulse, m_vp);
      chk("error", bus.ErrorSticky, {m_err1, m_err0});
`ifdef RUNAHEAD_CLEARQ_STATS_EN
      chk("stat_flushed", bus.FlushedWindows, m_flushed);
      chk("stat_validated", bus.ValidatedWindows, m_validated);
`endif
    end
  end

  task automatic cyc(input bit en, input bit enq, input bit iss, input bit endp,
                     input bit mis, input bit ack);
    bus.clk_en = en; bus.SpecEnqueue = enq; bus.SpecIssue = iss;
    bus.EndSpeculationPulse = endp; bus.MispredictedPulse = mis; bus.FlushAck = ack;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.clk_en = 1'b1; bus.SpecEnqueue = 0; bus.SpecIssue = 0;
    bus.EndSpeculationPulse = 0; bus.MispredictedPulse = 0; bus.FlushAck = 0;
    model_reset();
    #1;
    chk("rst_valid", bus.ClearQueueValid, 0);
    chk("rst_full", bus.ClearQueueFull, 0);
    chk("rst_flush_valid", bus.FlushValid, 0);
    chk("rst_flush_count", bus.FlushCount, 0);
    chk("rst_hold", bus.HoldIssue, 0);
    chk("rst_validated", bus.ValidatedPulse, 0);
    chk("rst_error", bus.ErrorSticky, 0);
    chk("rst_depth", bus.CurrentSpeculativeDepth, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clk_en = 1'b1; bus.SpecEnqueue = 0; bus.SpecIssue = 0;
    bus.EndSpeculationPulse = 0; bus.MispredictedPulse = 0; bus.FlushAck = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Correct window of 5.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("t1_depth5", bus.CurrentSpeculativeDepth, 5);
    cyc(1, 0, 0, 1, 0, 0);
    chk("t1_qvalid", bus.ClearQueueValid, 1);
    chk("t1_depth0", bus.CurrentSpeculativeDepth, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0);
    chk("t1_no_early_vp", bus.ValidatedPulse, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("t1_vp", bus.ValidatedPulse, 1);
    chk("t1_empty", bus.ClearQueueValid, 0);
    idle(1);
    chk("t1_vp_width", bus.ValidatedPulse, 0);

    // Mispredicted window of 3.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    chk("t2_fv", bus.FlushValid, 1);
    chk("t2_fc", bus.FlushCount, 3);
    chk("t2_hold", bus.HoldIssue, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t2_fv_drop", bus.FlushValid, 0);
    chk("t2_no_vp", bus.ValidatedPulse, 0);

    // Balanced enqueue/issue on empty queue closes an empty window.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("t3_qvalid", bus.ClearQueueValid, 0);
    chk("t3_depth", bus.CurrentSpeculativeDepth, 0);

    // Fill, pop+push at full, then overflow.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 1, 0, 0);
    chk("t4_full", bus.ClearQueueFull, 1);
    cyc(1, 1, 1, 1, 0, 0);
    chk("t4_full_keep", bus.ClearQueueFull, 1);
    chk("t4_no_err", bus.ErrorSticky, 0);
    cyc(1, 1, 0, 1, 0, 0);
    chk("t4_err", bus.ErrorSticky, 2'b01);
    chk("t4_full_after", bus.ClearQueueFull, 1);
    do_reset();

    // Windows {0,2},{1,3},{0,1}.
    cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("t5_vp1", bus.ValidatedPulse, 1);
    begin
      int waited = 0;
      while (bus.FlushValid !== 1'b1 && waited < 4) begin
        idle(1);
        waited++;
      end
      chk("t5_fv_timeout", waited < 4, 1);
    end
    chk("t5_fc", bus.FlushCount, 3);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t5_fv_drop", bus.FlushValid, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("t5_vp2", bus.ValidatedPulse, 1);
    chk("t5_empty", bus.ClearQueueValid, 0);

    // Reset during flush, then a fresh window of 2.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    chk("t6_fv", bus.FlushValid, 1);
    do_reset();
    cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(1, 0, 0, 1, 0, 0);
    chk("t6_qvalid", bus.ClearQueueValid, 1);
    cyc(1, 0, 1, 0, 0, 0); cyc(1, 0, 1, 0, 0, 0);
    chk("t6_vp", bus.ValidatedPulse, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 100) < 92, ($urandom % 100) < 50, ($urandom % 100) < 40,
          ($urandom % 100) < 12, ($urandom % 100) < 40, ($urandom % 100) < 50);
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < MAXC + 6; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("ovf_depth", bus.CurrentSpeculativeDepth, MAXC);
    chk("ovf_err", bus.ErrorSticky, 2'b10);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
